// File: rtl/ctrl_pkg.sv
// Shared control-word layout, PC-select encodings and branch-resolution helper
// for the ID/EX/MEM/WB control pipeline.
package ctrl_pkg;

    localparam int EX_W  = 5;
    localparam int MEM_W = 7;

    localparam int ALUOP_HI = 4;
    localparam int ALUOP_LO = 2;
    localparam int MEMREAD  = 1;
    localparam int MEMWRITE = 0;

    localparam int REGWRITE = 6;
    localparam int MEMTOREG = 5;
    localparam int PCTOREG  = 4;
    localparam int JUMP     = 3;
    localparam int JUMPMEM  = 2;
    localparam int BRN      = 1;
    localparam int BRZ      = 0;

    localparam logic [1:0] PC_SEL_SEQ = 2'd0;
    localparam logic [1:0] PC_SEL_REG = 2'd1;
    localparam logic [1:0] PC_SEL_MEM = 2'd2;

    localparam logic [EX_W-1:0]  BUBBLE_EX  = '0;
    localparam logic [MEM_W-1:0] BUBBLE_MEM = '0;

    function automatic logic isTaken(input logic [MEM_W-1:0] memCtrl,
                                     input logic             n,
                                     input logic             z);
        return memCtrl[JUMP] | memCtrl[JUMPMEM] | (memCtrl[BRN] & n) | (memCtrl[BRZ] & z);
    endfunction

endpackage

// File: rtl/ctrl_pipeline_stage_reg.sv
// Generic pipeline register: async active-low clear, synchronous bubble insert,
// and load enable.
module ctrl_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         flush_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (flush_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ctrl_pipeline.sv
// Control pipeline: carries decoded controls through ID/EX, EX/MEM, MEM/WB,
// resolves jumps/branches in MEM and detects load-use hazards.
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int REG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [EX_W-1:0]  id_ex_ctrl,
    input  logic [MEM_W-1:0] id_mem_ctrl,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             ex_n,
    input  logic             ex_z,
    output logic [2:0]       ex_aluop,
    output logic [REG_W-1:0] ex_rd,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic             wb_regwrite,
    output logic             wb_memtoreg,
    output logic             wb_pctoreg,
    output logic [REG_W-1:0] wb_rd,
    output logic [1:0]       pc_sel,
    output logic             stall,
    output logic             flush_ifid
);

    localparam int IDEX_W  = EX_W + MEM_W + REG_W;
    localparam int EXMEM_W = 2 + MEM_W + REG_W + 2;
    localparam int MEMWB_W = 3 + REG_W;

    logic [IDEX_W-1:0]  idEx_d,  idEx_q;
    logic [EXMEM_W-1:0] exMem_d, exMem_q;
    logic [MEMWB_W-1:0] memWb_d, memWb_q;

    logic [EX_W-1:0]  idExEx;
    logic [MEM_W-1:0] idExMem;
    logic [MEM_W-1:0] exMemCtrl;
    logic [REG_W-1:0] exMemRd;
    logic             exMemN;
    logic             exMemZ;
    logic             taken;

    assign idExEx  = idEx_q[IDEX_W-1 -: EX_W];
    assign idExMem = idEx_q[REG_W +: MEM_W];
    assign ex_rd   = idEx_q[REG_W-1:0];
    assign ex_aluop = idExEx[ALUOP_HI:ALUOP_LO];

    assign exMemZ       = exMem_q[0];
    assign exMemN       = exMem_q[1];
    assign exMemRd      = exMem_q[2 +: REG_W];
    assign exMemCtrl    = exMem_q[2 + REG_W +: MEM_W];
    assign mem_memwrite = exMem_q[EXMEM_W-2];
    assign mem_memread  = exMem_q[EXMEM_W-1];

    assign wb_regwrite = memWb_q[REG_W+2];
    assign wb_memtoreg = memWb_q[REG_W+1];
    assign wb_pctoreg  = memWb_q[REG_W];
    assign wb_rd       = memWb_q[REG_W-1:0];

    // A taken redirect in MEM suppresses the load-use stall: the dependent
    // instruction is about to be squashed anyway.
    assign taken      = isTaken(exMemCtrl, exMemN, exMemZ);
    assign flush_ifid = taken;
    assign stall      = id_valid & idExEx[MEMREAD]
                      & ((id_rs == ex_rd) | (id_rt == ex_rd)) & ~taken;

    always_comb begin
        pc_sel = PC_SEL_SEQ;
        if (exMemCtrl[JUMPMEM]) begin
            pc_sel = PC_SEL_MEM;
        end else if (taken) begin
            pc_sel = PC_SEL_REG;
        end
    end

    assign idEx_d  = id_valid ? {id_ex_ctrl, id_mem_ctrl, id_rd}
                              : {BUBBLE_EX, BUBBLE_MEM, {REG_W{1'b0}}};
    assign exMem_d = {idExEx[MEMREAD], idExEx[MEMWRITE], idExMem, ex_rd, ex_n, ex_z};
    assign memWb_d = {exMemCtrl[REGWRITE], exMemCtrl[MEMTOREG], exMemCtrl[PCTOREG], exMemRd};

    ctrl_stage_reg #(.W(IDEX_W)) uIdEx (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (1'b1),
        .flush_i (taken | stall),
        .d_i     (idEx_d),
        .q_o     (idEx_q)
    );

    ctrl_stage_reg #(.W(EXMEM_W)) uExMem (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (1'b1),
        .flush_i (taken),
        .d_i     (exMem_d),
        .q_o     (exMem_q)
    );

    // The branch itself still retires so link (PCtoReg) writes complete.
    ctrl_stage_reg #(.W(MEMWB_W)) uMemWb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (1'b1),
        .flush_i (1'b0),
        .d_i     (memWb_d),
        .q_o     (memWb_q)
    );

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline: table-driven single-instruction vectors,
// hand-written hazard/redirect/reset sequences, and a write-back scoreboard.
module tb_ctrl_pipeline;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_ex_ctrl;
    logic [6:0] id_mem_ctrl;
    logic [5:0] id_rs, id_rt, id_rd;
    logic       ex_n, ex_z;
    logic [2:0] ex_aluop;
    logic [5:0] ex_rd;
    logic       mem_memread, mem_memwrite;
    logic       wb_regwrite, wb_memtoreg, wb_pctoreg;
    logic [5:0] wb_rd;
    logic [1:0] pc_sel;
    logic       stall, flush_ifid;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] wb;
        logic [5:0] rd;
    } wb_t;

    wb_t sbQ[$];

    typedef struct packed {
        logic [4:0] ex;
        logic [6:0] mem;
        logic [5:0] rd;
        logic       n;
        logic       z;
        logic [2:0] expAlu;
        logic       expMemRead;
        logic       expMemWrite;
        logic [1:0] expPcSel;
        logic       expFlush;
        logic [2:0] expWb;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    ctrl_pipeline #(.REG_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_ex_ctrl   (id_ex_ctrl),
        .id_mem_ctrl  (id_mem_ctrl),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .ex_n         (ex_n),
        .ex_z         (ex_z),
        .ex_aluop     (ex_aluop),
        .ex_rd        (ex_rd),
        .mem_memread  (mem_memread),
        .mem_memwrite (mem_memwrite),
        .wb_regwrite  (wb_regwrite),
        .wb_memtoreg  (wb_memtoreg),
        .wb_pctoreg   (wb_pctoreg),
        .wb_rd        (wb_rd),
        .pc_sel       (pc_sel),
        .stall        (stall),
        .flush_ifid   (flush_ifid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] ex, input logic [6:0] mem,
                                 input logic [5:0] rs, input logic [5:0] rt, input logic [5:0] rd);
        id_valid    = v;
        id_ex_ctrl  = ex;
        id_mem_ctrl = mem;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        #1;
    endtask

    task automatic bubble();
        applyStimulus(1'b0, 5'b0, 7'b0, 6'd0, 6'd0, 6'd0);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic pushWb(input logic [2:0] bits, input logic [5:0] rd);
        if (bits != 3'b000) sbQ.push_back('{wb: bits, rd: rd});
    endtask

    function automatic int allOutputs();
        return int'({ex_aluop, ex_rd, mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg,
                     wb_pctoreg, wb_rd, pc_sel, stall, flush_ifid});
    endfunction

    // Every non-bubble write-back must match the oldest outstanding expectation.
    always @(negedge clk) begin : sbMon
        wb_t e;
        if (rst_n && (wb_regwrite | wb_memtoreg | wb_pctoreg)) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL wb_unexpected: got wb=%b rd=%0d, expected no write-back",
                         {wb_regwrite, wb_memtoreg, wb_pctoreg}, wb_rd);
            end else begin
                e = sbQ.pop_front();
                checkOutput("wb_bits", int'({wb_regwrite, wb_memtoreg, wb_pctoreg}), int'(e.wb));
                checkOutput("wb_rd", int'(wb_rd), int'(e.rd));
            end
        end
    end

    initial begin
        vecs[0]  = '{5'b10000, 7'b1000000, 6'd5,  1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 2'd0, 1'b0, 3'b100};
        vecs[1]  = '{5'b11110, 7'b1100000, 6'd3,  1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 2'd0, 1'b0, 3'b110};
        vecs[2]  = '{5'b01001, 7'b0000000, 6'd7,  1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 2'd0, 1'b0, 3'b000};
        vecs[3]  = '{5'b00000, 7'b0000010, 6'd0,  1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1, 1'b1, 3'b000};
        vecs[4]  = '{5'b00000, 7'b0000010, 6'd0,  1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000};
        vecs[5]  = '{5'b00100, 7'b0000001, 6'd0,  1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 2'd1, 1'b1, 3'b000};
        vecs[6]  = '{5'b00100, 7'b0000001, 6'd0,  1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000};
        vecs[7]  = '{5'b00000, 7'b0001000, 6'd0,  1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1, 1'b1, 3'b000};
        vecs[8]  = '{5'b00000, 7'b0010100, 6'd31, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'd2, 1'b1, 3'b001};
        vecs[9]  = '{5'b00000, 7'b1011000, 6'd30, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1, 1'b1, 3'b101};
        vecs[10] = '{5'b00000, 7'b0001100, 6'd0,  1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'd2, 1'b1, 3'b000};

        rst_n = 1'b0;
        ex_n  = 1'b0;
        ex_z  = 1'b0;
        bubble();
        #1;
        checkOutput("reset_state", allOutputs(), 0);
        #7;
        rst_n = 1'b1;
        advance();

        // Mid-flight reset: add in WB, load in MEM, add in EX.
        applyStimulus(1'b1, 5'b10000, 7'b1000000, 6'd1, 6'd1, 6'd9);
        advance();
        applyStimulus(1'b1, 5'b11110, 7'b1100000, 6'd1, 6'd1, 6'd3);
        advance();
        applyStimulus(1'b1, 5'b10000, 7'b1000000, 6'd1, 6'd1, 6'd8);
        advance();
        bubble();
        checkOutput("pre_reset_wb_regwrite", int'(wb_regwrite), 1);
        checkOutput("pre_reset_wb_rd", int'(wb_rd), 9);
        checkOutput("pre_reset_memread", int'(mem_memread), 1);
        checkOutput("pre_reset_aluop", int'(ex_aluop), 4);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_all", allOutputs(), 0);
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            advance();
            checkOutput("post_reset_bubble", allOutputs(), 0);
        end

        // Table-driven single-instruction vectors.
        for (int i = 0; i < NV; i++) begin
            applyStimulus(1'b1, vecs[i].ex, vecs[i].mem, 6'd60, 6'd61, vecs[i].rd);
            pushWb(vecs[i].expWb, vecs[i].rd);
            advance();
            ex_n = vecs[i].n;
            ex_z = vecs[i].z;
            bubble();
            checkOutput($sformatf("v%0d_aluop", i), int'(ex_aluop), int'(vecs[i].expAlu));
            checkOutput($sformatf("v%0d_ex_rd", i), int'(ex_rd), int'(vecs[i].rd));
            advance();
            ex_n = 1'b0;
            ex_z = 1'b0;
            #1;
            checkOutput($sformatf("v%0d_memread", i), int'(mem_memread), int'(vecs[i].expMemRead));
            checkOutput($sformatf("v%0d_memwrite", i), int'(mem_memwrite), int'(vecs[i].expMemWrite));
            checkOutput($sformatf("v%0d_pc_sel", i), int'(pc_sel), int'(vecs[i].expPcSel));
            checkOutput($sformatf("v%0d_flush", i), int'(flush_ifid), int'(vecs[i].expFlush));
            checkOutput($sformatf("v%0d_stall", i), int'(stall), 0);
            advance();
            advance();
        end

        // Load-use on rs: one stall cycle, bubble in EX, then the add proceeds.
        applyStimulus(1'b1, 5'b11110, 7'b1100000, 6'd1, 6'd2, 6'd3);
        pushWb(3'b110, 6'd3);
        advance();
        applyStimulus(1'b1, 5'b10000, 7'b1000000, 6'd3, 6'd4, 6'd6);
        pushWb(3'b100, 6'd6);
        checkOutput("lu_stall", int'(stall), 1);
        checkOutput("lu_no_flush", int'(flush_ifid), 0);
        advance();
        #1;
        checkOutput("lu_stall_released", int'(stall), 0);
        checkOutput("lu_bubble_aluop", int'(ex_aluop), 0);
        checkOutput("lu_bubble_rd", int'(ex_rd), 0);
        checkOutput("lu_load_in_mem", int'(mem_memread), 1);
        advance();
        bubble();
        checkOutput("lu_dep_aluop", int'(ex_aluop), 4);
        checkOutput("lu_dep_rd", int'(ex_rd), 6);
        for (int c = 0; c < 4; c++) advance();

        // Back-to-back loads through R0 and rt: each hazard stalls once.
        applyStimulus(1'b1, 5'b11110, 7'b1100000, 6'd1, 6'd1, 6'd0);
        pushWb(3'b110, 6'd0);
        advance();
        applyStimulus(1'b1, 5'b11110, 7'b1100000, 6'd5, 6'd0, 6'd2);
        pushWb(3'b110, 6'd2);
        checkOutput("b2b_stall1", int'(stall), 1);
        advance();
        #1;
        checkOutput("b2b_stall1_done", int'(stall), 0);
        advance();
        applyStimulus(1'b1, 5'b10000, 7'b1000000, 6'd2, 6'd9, 6'd4);
        pushWb(3'b100, 6'd4);
        checkOutput("b2b_stall2", int'(stall), 1);
        advance();
        #1;
        checkOutput("b2b_stall2_done", int'(stall), 0);
        advance();
        bubble();
        checkOutput("b2b_dep_rd", int'(ex_rd), 4);
        for (int c = 0; c < 4; c++) advance();

        // Jump in MEM with a load-use hazard pending: flush wins, younger stages squashed.
        applyStimulus(1'b1, 5'b00000, 7'b0001000, 6'd1, 6'd1, 6'd0);
        advance();
        applyStimulus(1'b1, 5'b11110, 7'b1100000, 6'd2, 6'd2, 6'd10);
        checkOutput("jt_no_stall_early", int'(stall), 0);
        advance();
        applyStimulus(1'b1, 5'b10000, 7'b1000000, 6'd10, 6'd4, 6'd11);
        checkOutput("jt_stall_suppressed", int'(stall), 0);
        checkOutput("jt_flush", int'(flush_ifid), 1);
        checkOutput("jt_pc_sel", int'(pc_sel), 1);
        advance();
        bubble();
        checkOutput("jt_ex_bubble_aluop", int'(ex_aluop), 0);
        checkOutput("jt_ex_bubble_rd", int'(ex_rd), 0);
        checkOutput("jt_mem_bubble", int'(mem_memread), 0);
        checkOutput("jt_pc_sel_after", int'(pc_sel), 0);
        checkOutput("jt_flush_after", int'(flush_ifid), 0);
        for (int c = 0; c < 4; c++) advance();

        checkOutput("sb_drained", sbQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
